// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam logic [5:0] MIN_PRESCALE = 6'd4;

   // Sample offsets around the bit centre (p/2).
   localparam int SMP_OFF_EARLY = -1;
   localparam int SMP_OFF_MID   = 0;
   localparam int SMP_OFF_LATE  = 1;

   function automatic logic [5:0] eff_prescale(input logic [5:0] p);
      return (p < MIN_PRESCALE) ? MIN_PRESCALE : p;
   endfunction

   function automatic logic [5:0] sample_point(input logic [5:0] p, input int off);
      return 6'(int'(p >> 1) + off);
   endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Three-point capture around the bit centre with a 2-of-3 majority vote.
module uart_rx_data_sampler
   import uart_rx_pkg::*;
(
   input  logic       CLK_RX,
   input  logic       RST,
   input  logic       S_RX_IN,
   input  logic [5:0] prescale,
   input  logic [5:0] edge_cnt,
   output logic       sampled_bit,
   output logic       sample_done
);

   logic [5:0] p_eff;
   logic [5:0] pt_early;
   logic [5:0] pt_mid;
   logic [5:0] pt_late;
   logic       s_early_q, s_early_d;
   logic       s_mid_q, s_mid_d;

   // The late sample is taken live so the vote is ready in the same cycle,
   // which matters at the minimum prescale where it lands on the bit's last edge.
   always_comb begin
      p_eff       = eff_prescale(prescale);
      pt_early    = sample_point(p_eff, SMP_OFF_EARLY);
      pt_mid      = sample_point(p_eff, SMP_OFF_MID);
      pt_late     = sample_point(p_eff, SMP_OFF_LATE);
      s_early_d   = s_early_q;
      s_mid_d     = s_mid_q;
      if (edge_cnt == pt_early) s_early_d = S_RX_IN;
      if (edge_cnt == pt_mid)   s_mid_d   = S_RX_IN;
      sample_done = (edge_cnt == pt_late);
      sampled_bit = (s_early_q & s_mid_q) | (s_early_q & S_RX_IN) | (s_mid_q & S_RX_IN);
   end

   always_ff @(posedge CLK_RX or posedge RST) begin
      if (RST) begin
         s_early_q <= 1'b0;
         s_mid_q   <= 1'b0;
      end else begin
         s_early_q <= s_early_d;
         s_mid_q   <= s_mid_d;
      end
   end

endmodule

// File: rtl/uart_rx_top.sv
// Oversampling UART receiver: FSM, edge/bit counters, deserializer and frame checks.
// Optional UART_RX_ERR_FLAGS_EN adds par_err / stp_err pulses for discarded frames.
module uart_rx_top
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK_RX,
   input  logic                  RST,
   input  logic                  S_RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            prescale,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid
`ifdef UART_RX_ERR_FLAGS_EN
   ,
   output logic                  par_err,
   output logic                  stp_err
`endif
);

   localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

   rx_state_e             state_q, state_d;
   logic [5:0]            edge_cnt_q, edge_cnt_d;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  data_valid_q, data_valid_d;
   logic                  par_flag_q, par_flag_d;
   logic                  bit_q, bit_d;
`ifdef UART_RX_ERR_FLAGS_EN
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;
`endif

   logic [5:0] p_eff;
   logic       bit_end;
   logic       cur_bit;
   logic       stop_bad;
   logic       sampled_bit;
   logic       sample_done;

   uart_rx_data_sampler u_sampler (
      .CLK_RX      (CLK_RX),
      .RST         (RST),
      .S_RX_IN     (S_RX_IN),
      .prescale    (prescale),
      .edge_cnt    (edge_cnt_q),
      .sampled_bit (sampled_bit),
      .sample_done (sample_done)
   );

   always_comb begin
      p_eff        = eff_prescale(prescale);
      bit_end      = (edge_cnt_q >= (p_eff - 6'd1));
      cur_bit      = sample_done ? sampled_bit : bit_q;
      bit_d        = cur_bit;
      state_d      = state_q;
      edge_cnt_d   = edge_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      p_data_d     = p_data_q;
      data_valid_d = 1'b0;
      par_flag_d   = par_flag_q;
      stop_bad     = 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
      par_err_d    = 1'b0;
      stp_err_d    = 1'b0;
`endif

      if (state_q != IDLE) edge_cnt_d = bit_end ? 6'd0 : (edge_cnt_q + 6'd1);

      case (state_q)
         IDLE: begin
            edge_cnt_d = 6'd0;
            bit_cnt_d  = '0;
            par_flag_d = 1'b0;
            // The detection cycle itself is edge 0 of the start bit.
            if (!S_RX_IN) begin
               state_d    = START;
               edge_cnt_d = 6'd1;
            end
         end
         START: begin
            if (bit_end) state_d = cur_bit ? IDLE : DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_d[bit_cnt_q] = cur_bit;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = PAR_EN ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               par_flag_d = cur_bit != ((^shift_q) ^ PAR_TYP);
               state_d    = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               stop_bad = ~cur_bit;
               if (!par_flag_q && !stop_bad) begin
                  p_data_d     = shift_q;
                  data_valid_d = 1'b1;
               end
`ifdef UART_RX_ERR_FLAGS_EN
               par_err_d = par_flag_q;
               stp_err_d = stop_bad;
`endif
               par_flag_d = 1'b0;
               // A low line here is already the next frame's start bit.
               if (!S_RX_IN) begin
                  state_d    = START;
                  edge_cnt_d = 6'd1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_RX or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         edge_cnt_q   <= 6'd0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_flag_q   <= 1'b0;
         bit_q        <= 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         edge_cnt_q   <= edge_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         par_flag_q   <= par_flag_d;
         bit_q        <= bit_d;
`ifdef UART_RX_ERR_FLAGS_EN
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
`endif
      end
   end

   assign P_DATA     = p_data_q;
   assign Data_Valid = data_valid_q;
`ifdef UART_RX_ERR_FLAGS_EN
   assign par_err    = par_err_q;
   assign stp_err    = stp_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top: frames driven bit by bit, pulses scored by cycle.
`timescale 1ns/1ps
module tb_uart_rx_top;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx;
   logic          par_en;
   logic          par_typ;
   logic [5:0]    prescale;
   logic [DW-1:0] p_data;
   logic          data_valid;
`ifdef UART_RX_ERR_FLAGS_EN
   logic          par_err;
   logic          stp_err;
   int            pe_cyc_q[$];
   int            se_cyc_q[$];
   int            exp_pe_q[$];
   int            exp_se_q[$];
`endif

   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            n_consec = 0;
   logic          dv_prev = 1'b0;
   logic [DW-1:0] exp_q[$];
   int            exp_cyc_q[$];
   logic [DW-1:0] obs_q[$];
   int            obs_cyc_q[$];
   int            s;
   logic [DW-1:0] d;

   uart_rx_top #(.DATA_WIDTH(DW)) dut (
      .CLK_RX     (clk),
      .RST        (rst),
      .S_RX_IN    (rx),
      .PAR_EN     (par_en),
      .PAR_TYP    (par_typ),
      .prescale   (prescale),
      .P_DATA     (p_data),
      .Data_Valid (data_valid)
`ifdef UART_RX_ERR_FLAGS_EN
      ,
      .par_err    (par_err),
      .stp_err    (stp_err)
`endif
   );

   // clock / reset-free cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // output monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (data_valid) begin
         obs_q.push_back(p_data);
         obs_cyc_q.push_back(cyc);
      end
      if (data_valid && dv_prev) n_consec++;
      dv_prev = data_valid;
`ifdef UART_RX_ERR_FLAGS_EN
      if (par_err) pe_cyc_q.push_back(cyc);
      if (stp_err) se_cyc_q.push_back(cyc);
`endif
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b, input int p);
      rx = b;
      idle(p);
   endtask

   task automatic send_frame(input logic [DW-1:0] data, input logic has_par,
                             input logic par_bit, input logic stop_bit, input int p);
      drive_bit(1'b0, p);
      for (int i = 0; i < DW; i++) drive_bit(data[i], p);
      if (has_par) drive_bit(par_bit, p);
      drive_bit(stop_bit, p);
      rx = 1'b1;
   endtask

   task automatic score(input string tag);
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         check({tag, "_data"}, obs_q.pop_front(), exp_q.pop_front());
         check({tag, "_cycle"}, obs_cyc_q.pop_front(), exp_cyc_q.pop_front());
      end
      obs_q.delete();
      obs_cyc_q.delete();
      exp_q.delete();
      exp_cyc_q.delete();
`ifdef UART_RX_ERR_FLAGS_EN
      check({tag, "_pe_count"}, pe_cyc_q.size(), exp_pe_q.size());
      while (pe_cyc_q.size() > 0 && exp_pe_q.size() > 0)
         check({tag, "_pe_cycle"}, pe_cyc_q.pop_front(), exp_pe_q.pop_front());
      check({tag, "_se_count"}, se_cyc_q.size(), exp_se_q.size());
      while (se_cyc_q.size() > 0 && exp_se_q.size() > 0)
         check({tag, "_se_cycle"}, se_cyc_q.pop_front(), exp_se_q.pop_front());
      pe_cyc_q.delete();
      se_cyc_q.delete();
      exp_pe_q.delete();
      exp_se_q.delete();
`endif
   endtask

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; rx = 1'b1; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd8;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_pdata", p_data, 0);
      check("rst_dv", data_valid, 0);
      idle(3);

      // even parity, p=8: A5 with parity 0, pulse 88 cycles after start
      par_en = 1'b1; par_typ = 1'b0; prescale = 6'd8;
      idle(2);
      exp_q.push_back(8'hA5); exp_cyc_q.push_back(cyc + 88);
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8);
      idle(8);
      score("even_par");
      check("even_par_pdata", p_data, 8'hA5);

      // no parity, p=16: 3C, pulse at 160
      par_en = 1'b0; prescale = 6'd16;
      idle(2);
      exp_q.push_back(8'h3C); exp_cyc_q.push_back(cyc + 160);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16);
      idle(16);
      score("no_par_p16");
      check("no_par_pdata", p_data, 8'h3C);

      // odd parity selected, parity bit 0 sent for A5: discarded
      par_en = 1'b1; par_typ = 1'b1; prescale = 6'd8;
      idle(2);
`ifdef UART_RX_ERR_FLAGS_EN
      exp_pe_q.push_back(cyc + 88);
`endif
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8);
      idle(8);
      score("par_err");
      check("par_err_pdata", p_data, 8'h3C);

      // stop bit 0: discarded
      par_en = 1'b0; par_typ = 1'b0;
      idle(2);
`ifdef UART_RX_ERR_FLAGS_EN
      exp_se_q.push_back(cyc + 80);
`endif
      send_frame(8'h12, 1'b0, 1'b0, 1'b0, 8);
      idle(24);
      score("stop_err");
      check("stop_err_pdata", p_data, 8'h3C);

      // start glitch of two clocks
      rx = 1'b0;
      idle(2);
      rx = 1'b1;
      idle(24);
      score("glitch");
      check("glitch_pdata", p_data, 8'h3C);

      // back-to-back frames with even parity
      par_en = 1'b1; par_typ = 1'b0;
      idle(2);
      exp_q.push_back(8'h55); exp_cyc_q.push_back(cyc + 88);
      exp_q.push_back(8'hAA); exp_cyc_q.push_back(cyc + 176);
      send_frame(8'h55, 1'b1, 1'b0, 1'b1, 8);
      send_frame(8'hAA, 1'b1, 1'b0, 1'b1, 8);
      idle(8);
      score("b2b");
      check("b2b_pdata", p_data, 8'hAA);

      // prescale below the minimum behaves as 4
      par_en = 1'b0; prescale = 6'd2;
      idle(2);
      exp_q.push_back(8'h96); exp_cyc_q.push_back(cyc + 40);
      send_frame(8'h96, 1'b0, 1'b0, 1'b1, 4);
      idle(8);
      score("min_prescale");
      check("min_prescale_pdata", p_data, 8'h96);

      // reset during data bit 4, then a clean frame
      prescale = 6'd8;
      idle(2);
      d = 8'hC3;
      drive_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
      rx = d[4];
      idle(3);
      rst = 1'b1;
      #1;
      check("midrst_pdata", p_data, 0);
      check("midrst_dv", data_valid, 0);
      rx = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(4);
      score("midrst_abort");
      exp_q.push_back(8'h81); exp_cyc_q.push_back(cyc + 80);
      send_frame(8'h81, 1'b0, 1'b0, 1'b1, 8);
      idle(8);
      score("after_rst");
      check("after_rst_pdata", p_data, 8'h81);

      check("dv_consecutive", n_consec, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_top.md
# uart_rx_top

Oversampling UART receiver: recovers one asynchronous serial frame from `S_RX_IN` (start, `DATA_WIDTH` data bits LSB first, optional parity, one stop bit) and presents it as a parallel word. `Data_Valid` is a single-cycle strobe. The block sits between the serial line (`S_RX_IN` already synchronised to `CLK_RX` upstream) and the parallel consumer. Bit timing comes from a runtime oversampling ratio `prescale`.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame and width of `P_DATA`.
- `CLK_RX`, input, 1: receive clock, rising edge. Runs at `prescale` × baud.
- `RST`, input, 1: asynchronous, active-high reset.
- `S_RX_IN`, input, 1: serial line. Idle is high.
- `PAR_EN`, input, 1: 1 means a parity bit follows the data bits.
- `PAR_TYP`, input, 1: 0 selects even parity, 1 selects odd parity.
- `prescale`, input, 6: clocks per bit. Supported values are 8, 16 and 32; any value from 4 to 63 works the same way; values below 4 are treated as 4.
- `P_DATA`, output, `DATA_WIDTH`: last correctly received word.
- `Data_Valid`, output, 1: one-cycle pulse when `P_DATA` has been updated with a good frame.

## Operation
- FSM states are IDLE, START, DATA, PARITY, STOP.
- An edge counter counts 0..`prescale`−1 within each bit. A bit counter tracks the data bit index.
- Sampling: three samples are taken at edge counts p/2−1, p/2 and p/2+1 (p = `prescale`). The bit value is the majority of the three.
- **IDLE:** when `S_RX_IN`=0 at a clock edge, go to START. That cycle is edge 0.
- **START:** if the sampled start bit is 1 (glitch), return to IDLE at the bit end. Otherwise go to DATA.
- **DATA:** data bit k is stored in shift-register position k, so the first bit received is LSB. After `DATA_WIDTH` bits, go to PARITY if `PAR_EN`=1, else go to STOP.
- **PARITY:**
  - Expected parity bit = XOR of the data bits when `PAR_TYP`=0; its inverse when `PAR_TYP`=1.
  - A mismatch sets an internal parity-error flag for the current frame.
- **STOP:** stop error if the sampled stop bit is 0.
- End of the stop bit (edge p−1):
  - If there is no parity error and no stop error, load `P_DATA` from the shift register and pulse `Data_Valid`.
  - Otherwise discard the frame: `P_DATA` is unchanged and no pulse is issued.
  - Next state is START if `S_RX_IN`=0 in that cycle (back-to-back frames), else IDLE.
- `PAR_EN`, `PAR_TYP` and `prescale` must be stable during a frame. They are sampled live.
- Reset: `P_DATA`=0, `Data_Valid`=0, FSM in IDLE, all counters and flags 0. Reset asserted mid-frame abandons the frame immediately.

## Timing
- Frame length is N bits: N = 2 + `DATA_WIDTH` + `PAR_EN` (11 with parity, 10 without, for width 8).
- Detection cycle = cycle 0. `P_DATA` and `Data_Valid` are registered and become visible after the clock edge ending cycle N·p−1. `Data_Valid` is high for exactly one cycle (p=8 with parity: high during cycle 88).
- `Data_Valid` is never high in two consecutive cycles.

## Configuration
- Macro: `UART_RX_ERR_FLAGS_EN`.
- **When defined:** adds two outputs, `par_err` and `stp_err`.
  - Each is a one-cycle pulse, issued in the same cycle the `Data_Valid` pulse would occur.
  - Each flags its error on a discarded frame.
  - Reset value is 0.
- **When undefined:** these ports do not exist and errors are only silent discards.

## Structure
- Package `uart_rx_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - the minimum-prescale constant (4);
  - the sample-offset constants (−1, 0, +1 around p/2).
- Sub-module `uart_rx_data_sampler` holds the three-sample capture and majority vote. Its inputs are `CLK_RX`, `RST`, `S_RX_IN`, `prescale` and the edge count; its outputs are the sampled bit and a sample-done strobe.
- The top level contains the FSM, counters, deserializer and checkers.

## Test plan
- **Good frame with even parity:** p=8, `PAR_EN`=1, `PAR_TYP`=0; send start, bits 1,0,1,0,0,1,0,1, parity 0, stop 1. Expect `P_DATA`=8'hA5 and one `Data_Valid` pulse in cycle 88.
- **No parity, larger prescale:** p=16, `PAR_EN`=0; send 8'h3C LSB first. Expect `P_DATA`=8'h3C and `Data_Valid` in cycle 160.
- **Parity error:** p=8, `PAR_TYP`=1; send 8'hA5 with parity 0. Expect no `Data_Valid` and `P_DATA` unchanged; with the macro, `par_err` pulses in cycle 88.
- **Stop error and start glitch:**
  - Stop bit 0 → frame discarded, `stp_err` pulses with the macro.
  - Start low for only 2 clocks → return to IDLE, no output.
- **Back-to-back frames:** p=8, no idle between two frames, 8'h55 then 8'hAA. Expect two pulses 88 cycles apart with the correct data.
- **Reset mid-frame:** assert `RST` during data bit 4. Outputs go to 0 at once; a subsequent full frame is received correctly.
